m10k_stream_fifo: RTL

M10K_STREAM_FIFO -- requirements
Module: m10k_stream_fifo

---
 rtl/m10k_stream_fifo.sv | 136 +++++++++++++
 1 files changed

// File: rtl/m10k_stream_fifo.sv
// Streaming FIFO backed by an M10K-style simple dual-port RAM with a 2-cycle registered read,
// followed by a 3-entry first-word-fall-through output buffer.
module m10k_stream_fifo #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 100,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH+3):0]  level
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int LW  = $clog2(DEPTH + 3) + 1;

  (* ramstyle = "no_rw_check, M10K" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0]         mem_count_q, mem_count_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] ram_rd_q;
  logic [DATA_WIDTH-1:0] buf_data_q [3];
  logic [DATA_WIDTH-1:0] buf_data_d [3];
  logic [1:0]            buf_count_q, buf_count_d;

  logic       push;
  logic       pop;
  logic       issue;
  logic [2:0] pend;
  logic [1:0] buf_wr_idx;

  // A slot freed by a read issue is still being read on the following edge, so it is not
  // offered for writing until that read has sampled the array.
  assign in_ready  = !reset && ((CW1'(mem_count_q) + CW1'(s1_valid_q)) < CW1'(DEPTH));
  assign out_valid = (buf_count_q != 2'd0);
  assign out_data  = buf_data_q[0];
  assign level     = LW'(mem_count_q) + LW'(s1_valid_q) + LW'(s2_valid_q) + LW'(buf_count_q);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_addr_d   = rd_addr_q;
    mem_count_d = mem_count_q;
    buf_data_d  = buf_data_q;
    buf_count_d = buf_count_q;

    push  = in_valid && in_ready && !clear;
    pop   = out_valid && out_ready && !clear;
    // Reads in flight plus buffered words after this cycle's pop must leave room to land.
    pend  = 3'(s1_valid_q) + 3'(s2_valid_q) + 3'(buf_count_q) - 3'(pop);
    issue = !clear && (mem_count_q != '0) && (pend < 3'd3);

    if (push) begin
      wr_ptr_d = (wr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (issue) begin
      rd_ptr_d  = (rd_ptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
      rd_addr_d = rd_ptr_q;
    end
    mem_count_d = mem_count_q + CW'(push) - CW'(issue);
    s1_valid_d  = issue;
    s2_valid_d  = s1_valid_q;

    // Shift only when another word follows, so out_data keeps the last word once empty.
    if (pop && (buf_count_q > 2'd1)) begin
      buf_data_d[0] = buf_data_q[1];
      buf_data_d[1] = buf_data_q[2];
    end
    buf_wr_idx = buf_count_q - 2'(pop);
    if (s2_valid_q) begin
      buf_data_d[buf_wr_idx] = ram_rd_q;
    end
    buf_count_d = buf_count_q - 2'(pop) + 2'(s2_valid_q);

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      mem_count_d = '0;
      s1_valid_d  = 1'b0;
      s2_valid_d  = 1'b0;
      buf_count_d = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_addr_q   <= '0;
      mem_count_q <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      buf_count_q <= 2'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_addr_q   <= rd_addr_d;
      mem_count_q <= mem_count_d;
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      buf_count_q <= buf_count_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_buf
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          buf_data_q[gi] <= '0;
        end else begin
          buf_data_q[gi] <= buf_data_d[gi];
        end
      end
    end
  endgenerate

  // RAM array and its output register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
    ram_rd_q <= mem[rd_addr_q];
  end

endmodule
